monitor_baterias_param: RTL and testbench
=========================================

// Module: monitor_baterias_param
// PURPOSE
//   Parametrised, clocked successor of the two-battery monitor. Samples N_BAT charge words of ANCHO bits.
//   Produces a per-battery low-charge warning with hysteresis and a debounced aggregate health state
//   (optimo/aceptable/regular/critico), plus a sticky critical alarm. Sits between the charge ADC
//   sampler and the supervisory/LED logic.
// PARAMETERS
//   N_BAT       2  number of batteries (>=1)
//   ANCHO       4  bits per charge word; full scale MAXC = 2**ANCHO-1
//   UMBRAL_ADV  4  warning sets when carga < UMBRAL_ADV
//   HISTERESIS  2  warning clears when carga >= UMBRAL_ADV+HISTERESIS (sum must be <= MAXC)
//   FILTRO      3  consecutive valid samples required to change any output (>=1; 1 = no debounce)
// PORTS
//   clk              in   1              single clock; all state on rising edge
//   rst              in   1              synchronous, active-high reset
//   muestra_valida   in   1              charge bus holds a new sample this cycle
//   carga            in   N_BAT*ANCHO    battery i at [i*ANCHO +: ANCHO]
//   ack_alarma       in   1              clears alarma_critica
//   advertencia      out  N_BAT          per-battery low-charge warning
//   num_advertencias out  $clog2(N_BAT+1)  popcount of advertencia (registered)
//   optimo,aceptable,regular,critico  out 1 each  one-hot aggregate state
//   cambio_estado    out  1              1-cycle pulse when aggregate state changes
//   alarma_critica   out  1              sticky; set on entry to critico
// BEHAVIOUR
//   Reset: advertencia=0, num_advertencias=0, optimo=1, others=0, cambio_estado=0, alarma_critica=0,
//     all filter counters and candidates cleared. Reset mid-count discards partial counts.
//   Cycles with muestra_valida=0 hold every counter and output (except cambio_estado, which returns to 0).
//   Per-battery warning filter, per valid sample:
//     - If warning=0 and carga<UMBRAL_ADV: cnt++; else cnt=0.
//     - If warning=1 and carga>=UMBRAL_ADV+HISTERESIS: cnt++; else cnt=0.
//     - When cnt reaches FILTRO: toggle warning and clear cnt. Values in the hysteresis band reset cnt.
//   Aggregate level: SUMA = sum of all charges (width ANCHO+$clog2(N_BAT)+2, no overflow).
//     MAXS = N_BAT*MAXC. Compare exactly in integers:
//     - 4*SUMA>=3*MAXS -> OPTIMO
//     - 4*SUMA>=2*MAXS -> ACEPTABLE
//     - 4*SUMA>=MAXS -> REGULAR
//     - else CRITICO
//   State machine {OPTIMO, ACEPTABLE, REGULAR, CRITICO}, debounced, per valid sample:
//     - If level==state: run=0.
//     - Else if level==cand: run++.
//     - Else: cand=level, run=1.
//     - When run reaches FILTRO: state<=cand, run=0, cambio_estado=1 next cycle.
//     Any state-to-state jump is legal (no stepping).
//   Latency: outputs update on the clock edge that registers the FILTRO-th qualifying sample.
//     They are visible one cycle after that sample is presented.
//   alarma_critica: set when state enters CRITICO. Cleared by ack_alarma. Set wins if both occur in
//     the same cycle. Ack while already in CRITICO clears it; it is not re-set until the next entry.
//   num_advertencias is updated in the same cycle as advertencia.
// STRUCTURE
//   Package monitor_baterias_pkg:
//     - estado_t enum (OPTIMO=0, ACEPTABLE, REGULAR, CRITICO)
//     - function nivel(suma, maxs) returning estado_t
//     - one-hot decode helper
//   Sub-module filtro_advertencia (one channel: cnt, warning, hysteresis), instantiated N_BAT times
//   in a generate loop. Summation, aggregate FSM and alarm are in the top.
// TESTING (N_BAT=2, ANCHO=4, UMBRAL_ADV=4, HISTERESIS=2, FILTRO=3; MAXS=30)
//   1. rst, then carga={0,0} for 3 valid samples:
//      advertencia=2'b11, num=2, critico=1, alarma_critica=1, one cambio_estado pulse.
//   2. {15,15} x2, {0,0} x1, then {15,15} x3:
//      no change until the third run, then optimo=1 and advertencia=00.
//   3. Warning set on bat0; bat0=5 x5 -> warning held; bat0=6 x3 -> warning clears.
//   4. Boundaries:
//      - {8,7} (sum 15) x3 -> aceptable
//      - {7,7} (sum 14) x3 -> regular
//      - {4,3} (sum 7) x3 -> critico
//      - {4,4} (sum 8) x3 -> regular
//   5. ack_alarma asserted the same cycle critico is entered -> alarma_critica=1.
//      Later ack alone -> alarma_critica=0.
//   6. Gaps in muestra_valida between qualifying samples do not break runs.
//      rst asserted after 2 of 3 samples -> reset values, and 3 fresh samples are needed.

Source files
------------

// File: rtl/monitor_baterias_pkg.sv
// Shared types and helpers for the parametrised battery monitor:
// aggregate health state, level classification and one-hot decode.
package monitor_baterias_pkg;

  typedef enum logic [1:0] {
    OPTIMO    = 2'd0,
    ACEPTABLE = 2'd1,
    REGULAR   = 2'd2,
    CRITICO   = 2'd3
  } estado_t;

  // Classifies the charge sum against quarters of full scale using exact
  // integer comparisons (4*suma against k*maxs), so no division is needed.
  function automatic estado_t nivel(input logic [31:0] suma, input logic [31:0] maxs);
    logic [35:0] s4;
    logic [35:0] m;
    estado_t     r;
    s4 = {2'b00, suma, 2'b00};
    m  = {4'b0000, maxs};
    if (s4 >= 36'd3 * m) begin
      r = OPTIMO;
    end else if (s4 >= 36'd2 * m) begin
      r = ACEPTABLE;
    end else if (s4 >= m) begin
      r = REGULAR;
    end else begin
      r = CRITICO;
    end
    return r;
  endfunction

  // One-hot decode ordered {critico, regular, aceptable, optimo}.
  function automatic logic [3:0] decodificar(input estado_t e);
    logic [3:0] r;
    case (e)
      OPTIMO:    r = 4'b0001;
      ACEPTABLE: r = 4'b0010;
      REGULAR:   r = 4'b0100;
      CRITICO:   r = 4'b1000;
      default:   r = 4'b0001;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/monitor_baterias_param_filtro.sv
// One battery channel: low-charge warning with hysteresis, debounced by a
// run of FILTRO consecutive qualifying valid samples.
module filtro_advertencia
  import monitor_baterias_pkg::*;
#(
  parameter int ANCHO      = 4,
  parameter int UMBRAL_ADV = 4,
  parameter int HISTERESIS = 2,
  parameter int FILTRO     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             muestra_valida,
  input  logic [ANCHO-1:0] carga,
  output logic             advertencia,
  output logic             advertencia_sig
);

  localparam int CW = $clog2(FILTRO + 1);
  localparam int UMB_SET_I = UMBRAL_ADV;
  localparam int UMB_CLR_I = UMBRAL_ADV + HISTERESIS;
  localparam logic [ANCHO-1:0] UMB_SET = UMB_SET_I[ANCHO-1:0];
  localparam logic [ANCHO-1:0] UMB_CLR = UMB_CLR_I[ANCHO-1:0];
  localparam logic [CW-1:0]    FILTRO_C = CW'(FILTRO);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          califica;

  // Qualifying condition depends on the current warning; band values never qualify.
  always_comb begin
    califica        = 1'b0;
    cnt_inc         = cnt + CW'(1);
    advertencia_sig = advertencia;
    if (advertencia) begin
      califica = (carga >= UMB_CLR);
    end else begin
      califica = (carga < UMB_SET);
    end
    if (muestra_valida && califica && (cnt_inc == FILTRO_C)) begin
      advertencia_sig = ~advertencia;
    end else begin
      advertencia_sig = advertencia;
    end
  end

  // Run counter and warning flag; a toggle restarts the run from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      advertencia <= 1'b0;
    end else if (muestra_valida) begin
      if (!califica) begin
        cnt <= '0;
      end else if (cnt_inc == FILTRO_C) begin
        cnt         <= '0;
        advertencia <= ~advertencia;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/monitor_baterias_param.sv
// Parametrised battery monitor: per-battery warnings, debounced aggregate
// health state machine and sticky critical alarm.
module monitor_baterias_param
  import monitor_baterias_pkg::*;
#(
  parameter int N_BAT      = 2,
  parameter int ANCHO      = 4,
  parameter int UMBRAL_ADV = 4,
  parameter int HISTERESIS = 2,
  parameter int FILTRO     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       muestra_valida,
  input  logic [N_BAT*ANCHO-1:0]     carga,
  input  logic                       ack_alarma,
  output logic [N_BAT-1:0]           advertencia,
  output logic [$clog2(N_BAT+1)-1:0] num_advertencias,
  output logic                       optimo,
  output logic                       aceptable,
  output logic                       regular,
  output logic                       critico,
  output logic                       cambio_estado,
  output logic                       alarma_critica
);

  localparam int NW = $clog2(N_BAT + 1);
  localparam int SW = ANCHO + $clog2(N_BAT) + 2;
  localparam int CW = $clog2(FILTRO + 1);
  localparam logic [31:0]   MAXS     = 32'(N_BAT * ((2 ** ANCHO) - 1));
  localparam logic [CW-1:0] FILTRO_C = CW'(FILTRO);

  logic [N_BAT-1:0] advertencia_sig;
  logic [NW-1:0]    popcount;
  logic [SW-1:0]    suma;
  estado_t          lvl;
  estado_t          estado;
  estado_t          cand;
  logic [CW-1:0]    run;
  logic [CW-1:0]    run_inc;

  genvar gi;
  generate
    for (gi = 0; gi < N_BAT; gi++) begin : g_canal
      filtro_advertencia #(
        .ANCHO      (ANCHO),
        .UMBRAL_ADV (UMBRAL_ADV),
        .HISTERESIS (HISTERESIS),
        .FILTRO     (FILTRO)
      ) u_filtro (
        .clk             (clk),
        .rst             (rst),
        .muestra_valida  (muestra_valida),
        .carga           (carga[gi*ANCHO +: ANCHO]),
        .advertencia     (advertencia[gi]),
        .advertencia_sig (advertencia_sig[gi])
      );
    end
  endgenerate

  // Warning count of the next-cycle flags so it lands with advertencia.
  always_comb begin
    popcount = '0;
    for (int i = 0; i < N_BAT; i++) begin
      popcount = popcount + NW'(advertencia_sig[i]);
    end
  end

  // Registered popcount of the warnings.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_advertencias <= '0;
    end else begin
      num_advertencias <= popcount;
    end
  end

  // Charge sum, its level, and the candidate run length if this sample counts.
  always_comb begin
    suma = '0;
    for (int i = 0; i < N_BAT; i++) begin
      suma = suma + SW'(carga[i*ANCHO +: ANCHO]);
    end
    lvl = nivel(32'(suma), MAXS);
    if (lvl == cand) begin
      run_inc = run + CW'(1);
    end else begin
      run_inc = CW'(1);
    end
  end

  // Debounced aggregate FSM with registered one-hot outputs, change pulse
  // and sticky alarm (entry to CRITICO overrides a simultaneous ack).
  always_ff @(posedge clk) begin
    if (rst) begin
      estado         <= OPTIMO;
      cand           <= OPTIMO;
      run            <= '0;
      cambio_estado  <= 1'b0;
      alarma_critica <= 1'b0;
      {critico, regular, aceptable, optimo} <= 4'b0001;
    end else begin
      cambio_estado <= 1'b0;
      if (ack_alarma) begin
        alarma_critica <= 1'b0;
      end
      if (muestra_valida) begin
        if (lvl == estado) begin
          run <= '0;
        end else if (run_inc == FILTRO_C) begin
          estado        <= lvl;
          cand          <= lvl;
          run           <= '0;
          cambio_estado <= 1'b1;
          {critico, regular, aceptable, optimo} <= decodificar(lvl);
          if (lvl == CRITICO) begin
            alarma_critica <= 1'b1;
          end
        end else begin
          cand <= lvl;
          run  <= run_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_monitor_baterias_param.sv
// Directed self-checking bench for monitor_baterias_param (default parameters).
// Status word compared: {advertencia[1:0], num[1:0], critico, regular,
// aceptable, optimo, cambio_estado, alarma_critica}.
module tb_monitor_baterias_param;

  logic       clk;
  logic       rst;
  logic       muestra_valida;
  logic [7:0] carga;
  logic       ack_alarma;
  logic [1:0] advertencia;
  logic [1:0] num_advertencias;
  logic       optimo, aceptable, regular, critico;
  logic       cambio_estado;
  logic       alarma_critica;
  logic [9:0] st;

  int passed = 0;
  int total  = 0;

  monitor_baterias_param dut (
    .clk              (clk),
    .rst              (rst),
    .muestra_valida   (muestra_valida),
    .carga            (carga),
    .ack_alarma       (ack_alarma),
    .advertencia      (advertencia),
    .num_advertencias (num_advertencias),
    .optimo           (optimo),
    .aceptable        (aceptable),
    .regular          (regular),
    .critico          (critico),
    .cambio_estado    (cambio_estado),
    .alarma_critica   (alarma_critica)
  );

  assign st = {advertencia, num_advertencias, critico, regular, aceptable, optimo,
               cambio_estado, alarma_critica};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one valid sample {bat1, bat0}; returns at the next falling edge.
  task automatic apply(input logic [3:0] c1, input logic [3:0] c0, input logic ack);
    muestra_valida = 1'b1;
    carga          = {c1, c0};
    ack_alarma     = ack;
    @(negedge clk);
    muestra_valida = 1'b0;
    ack_alarma     = 1'b0;
  endtask

  // One cycle without a valid sample.
  task automatic idle(input logic ack);
    muestra_valida = 1'b0;
    ack_alarma     = ack;
    @(negedge clk);
    ack_alarma     = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    muestra_valida = 1'b0;
    ack_alarma = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_rst();
    total++;
    if (st !== 10'b00_00_0001_0_0) $display("FAIL reset got %b want %b", st, 10'b00_00_0001_0_0);
    else passed++;
  endtask

  task automatic test_entrada_critico();
    int pulsos;
    pulsos = 0;
    apply(4'd0, 4'd0, 1'b0);
    pulsos += int'(cambio_estado);
    total++;
    if (st !== 10'b00_00_0001_0_0) $display("FAIL crit_s1 got %b want %b", st, 10'b00_00_0001_0_0);
    else passed++;
    apply(4'd0, 4'd0, 1'b0);
    pulsos += int'(cambio_estado);
    apply(4'd0, 4'd0, 1'b0);
    pulsos += int'(cambio_estado);
    total++;
    if (st !== 10'b11_10_1000_1_1) $display("FAIL crit_s3 got %b want %b", st, 10'b11_10_1000_1_1);
    else passed++;
    idle(1'b0);
    pulsos += int'(cambio_estado);
    total++;
    if (st !== 10'b11_10_1000_0_1) $display("FAIL crit_hold got %b want %b", st, 10'b11_10_1000_0_1);
    else passed++;
    total++;
    if (pulsos !== 1) $display("FAIL crit_pulses got %0d want 1", pulsos);
    else passed++;
  endtask

  task automatic test_run_roto();
    apply(4'd15, 4'd15, 1'b0);
    apply(4'd15, 4'd15, 1'b0);
    apply(4'd0, 4'd0, 1'b0);
    apply(4'd15, 4'd15, 1'b0);
    apply(4'd15, 4'd15, 1'b0);
    total++;
    if (st !== 10'b11_10_1000_0_1) $display("FAIL run_break got %b want %b", st, 10'b11_10_1000_0_1);
    else passed++;
    apply(4'd15, 4'd15, 1'b0);
    total++;
    if (st !== 10'b00_00_0001_1_1) $display("FAIL run_opt got %b want %b", st, 10'b00_00_0001_1_1);
    else passed++;
  endtask

  task automatic test_histeresis();
    // bat0 low, bat1 full: sum 15 is exactly the ACEPTABLE threshold.
    for (int i = 0; i < 3; i++) apply(4'd15, 4'd0, 1'b0);
    total++;
    if (st !== 10'b01_01_0010_1_1) $display("FAIL hyst_set got %b want %b", st, 10'b01_01_0010_1_1);
    else passed++;
    for (int i = 0; i < 5; i++) apply(4'd15, 4'd5, 1'b0);
    total++;
    if (st !== 10'b01_01_0010_0_1) $display("FAIL hyst_band got %b want %b", st, 10'b01_01_0010_0_1);
    else passed++;
    apply(4'd15, 4'd6, 1'b0);
    apply(4'd15, 4'd6, 1'b0);
    total++;
    if (st !== 10'b01_01_0010_0_1) $display("FAIL hyst_clr2 got %b want %b", st, 10'b01_01_0010_0_1);
    else passed++;
    apply(4'd15, 4'd6, 1'b0);
    total++;
    if (st !== 10'b00_00_0010_0_1) $display("FAIL hyst_clr3 got %b want %b", st, 10'b00_00_0010_0_1);
    else passed++;
    idle(1'b1);
    total++;
    if (st !== 10'b00_00_0010_0_0) $display("FAIL ack_clear got %b want %b", st, 10'b00_00_0010_0_0);
    else passed++;
  endtask

  task automatic test_limites();
    for (int i = 0; i < 3; i++) apply(4'd8, 4'd7, 1'b0);
    total++;
    if (st !== 10'b00_00_0010_0_0) $display("FAIL lim_15 got %b want %b", st, 10'b00_00_0010_0_0);
    else passed++;
    for (int i = 0; i < 3; i++) apply(4'd7, 4'd7, 1'b0);
    total++;
    if (st !== 10'b00_00_0100_1_0) $display("FAIL lim_14 got %b want %b", st, 10'b00_00_0100_1_0);
    else passed++;
    for (int i = 0; i < 3; i++) apply(4'd4, 4'd3, 1'b0);
    total++;
    if (st !== 10'b01_01_1000_1_1) $display("FAIL lim_7 got %b want %b", st, 10'b01_01_1000_1_1);
    else passed++;
    for (int i = 0; i < 3; i++) apply(4'd4, 4'd4, 1'b0);
    total++;
    if (st !== 10'b01_01_0100_1_1) $display("FAIL lim_8 got %b want %b", st, 10'b01_01_0100_1_1);
    else passed++;
  endtask

  task automatic test_alarma();
    idle(1'b1);
    total++;
    if (st !== 10'b01_01_0100_0_0) $display("FAIL alm_ack got %b want %b", st, 10'b01_01_0100_0_0);
    else passed++;
    apply(4'd0, 4'd0, 1'b0);
    apply(4'd0, 4'd0, 1'b0);
    apply(4'd0, 4'd0, 1'b1);
    total++;
    if (st !== 10'b11_10_1000_1_1) $display("FAIL alm_setwins got %b want %b", st, 10'b11_10_1000_1_1);
    else passed++;
    idle(1'b1);
    total++;
    if (st !== 10'b11_10_1000_0_0) $display("FAIL alm_ackcrit got %b want %b", st, 10'b11_10_1000_0_0);
    else passed++;
    for (int i = 0; i < 3; i++) apply(4'd0, 4'd0, 1'b0);
    total++;
    if (st !== 10'b11_10_1000_0_0) $display("FAIL alm_noreset got %b want %b", st, 10'b11_10_1000_0_0);
    else passed++;
  endtask

  task automatic test_huecos_y_reset();
    apply(4'd15, 4'd15, 1'b0);
    idle(1'b0);
    idle(1'b0);
    apply(4'd15, 4'd15, 1'b0);
    idle(1'b0);
    total++;
    if (st !== 10'b11_10_1000_0_0) $display("FAIL gap_2 got %b want %b", st, 10'b11_10_1000_0_0);
    else passed++;
    apply(4'd15, 4'd15, 1'b0);
    total++;
    if (st !== 10'b00_00_0001_1_0) $display("FAIL gap_3 got %b want %b", st, 10'b00_00_0001_1_0);
    else passed++;
    apply(4'd0, 4'd0, 1'b0);
    idle(1'b0);
    apply(4'd0, 4'd0, 1'b0);
    pulse_rst();
    total++;
    if (st !== 10'b00_00_0001_0_0) $display("FAIL midrst got %b want %b", st, 10'b00_00_0001_0_0);
    else passed++;
    apply(4'd0, 4'd0, 1'b0);
    apply(4'd0, 4'd0, 1'b0);
    total++;
    if (st !== 10'b00_00_0001_0_0) $display("FAIL fresh_2 got %b want %b", st, 10'b00_00_0001_0_0);
    else passed++;
    apply(4'd0, 4'd0, 1'b0);
    total++;
    if (st !== 10'b11_10_1000_1_1) $display("FAIL fresh_3 got %b want %b", st, 10'b11_10_1000_1_1);
    else passed++;
  endtask

  initial begin
    rst            = 1'b1;
    muestra_valida = 1'b0;
    carga          = 8'd0;
    ack_alarma     = 1'b0;
    @(negedge clk);
    test_reset();
    test_entrada_critico();
    test_run_roto();
    test_histeresis();
    test_limites();
    test_alarma();
    test_huecos_y_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
